// File: rtl/display_scheduler.sv
// display_scheduler: time-shares the two-digit seven-segment display among
// N_SRC 8-bit sources. Auto mode rotates through the valid sources with a
// dwell time; manual mode follows sel. A blank gap separates sources.
// All outputs are registered.
module display_scheduler #(
  parameter int N_SRC = 4,
  parameter int DWELL = 50_000_000,
  parameter int GAP   = 1_000_000,
  localparam int SW   = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [8*N_SRC-1:0]   src_data,
  input  logic [N_SRC-1:0]     src_valid,
  input  logic                 mode,
  input  logic [SW-1:0]        sel,
  input  logic                 freeze,
  output logic [7:0]           data_out,
  output logic                 disp_en,
  output logic [SW-1:0]        cur_src,
  output logic                 changed
);

  // One counter serves both the dwell and the gap; it is sized for the larger.
  localparam int MAXC = (DWELL > GAP) ? DWELL : GAP;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] GAP_LAST   = (GAP > 0) ? CW'(GAP - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     cur_q, cur_d;
  logic [SW-1:0]     nxt_q, nxt_d;
  logic [7:0]        data_q, data_d;
  logic              en_q, en_d;
  logic              chg_q, chg_d;
  logic              mode_q, mode_d;

  logic [N_SRC-1:0][7:0] src_arr;
  logic [SW:0]           nxt_auto;  // {found, index} searching from cur+1 with wrap
  logic [SW:0]           low;       // {found, index} lowest valid source
  logic [SW-1:0]         tgt;
  logic                  go;

  assign src_arr = src_data;

  // First valid index at or after 'start' (modulo N_SRC); MSB flags a hit.
  function automatic logic [SW:0] find_valid(input logic [N_SRC-1:0] v,
                                             input int start);
    logic [SW:0] r;
    int          idx;
    r = '0;
    for (int i = 0; i < N_SRC; i++) begin
      idx = (start + i) % N_SRC;
      if (!r[SW] && v[SW'(idx)]) r = {1'b1, SW'(idx)};
    end
    return r;
  endfunction

  assign nxt_auto = find_valid(src_valid, int'(cur_q) + 1);
  assign low      = find_valid(src_valid, 0);

  // Next-state logic: source selection, dwell/gap timing and registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    data_d  = data_q;
    en_d    = en_q;
    chg_d   = 1'b0;
    mode_d  = mode_q;
    tgt     = cur_q;
    go      = 1'b0;

    if (!freeze) begin
      mode_d = mode;
      case (state_q)
        S_IDLE: begin
          if (low[SW]) begin
            state_d = S_SHOW;
            cnt_d   = '0;
            chg_d   = 1'b1;
            cur_d   = (mode && src_valid[sel]) ? sel : low[SW-1:0];
          end
        end

        S_SHOW: begin
          // Counter runs only in auto mode and restarts on any mode change.
          cnt_d = (mode || (mode != mode_q)) ? '0 : cnt_q + 1'b1;
          // Priority: losing the current source, then dwell expiry, then sel.
          if (!src_valid[cur_q]) begin
            if (nxt_auto[SW]) begin
              tgt = nxt_auto[SW-1:0];
              go  = 1'b1;
            end else begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end
          end else if (!mode && (mode == mode_q) && (cnt_q == DWELL_LAST)) begin
            // Only source left: stay put silently and start a fresh dwell.
            cnt_d = '0;
            if (nxt_auto[SW-1:0] != cur_q) begin
              tgt = nxt_auto[SW-1:0];
              go  = 1'b1;
            end
          end else if (mode && (sel != cur_q) && src_valid[sel]) begin
            tgt = sel;
            go  = 1'b1;
          end

          if (go) begin
            cnt_d = '0;
            if (GAP == 0) begin
              cur_d = tgt;
              chg_d = 1'b1;
            end else begin
              state_d = S_GAP;
              nxt_d   = tgt;
            end
          end
        end

        S_GAP: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == GAP_LAST) begin
            cnt_d = '0;
            // The chosen source may have gone away during the gap.
            if (src_valid[nxt_q]) begin
              state_d = S_SHOW;
              cur_d   = nxt_q;
              chg_d   = 1'b1;
            end else if (nxt_auto[SW]) begin
              state_d = S_SHOW;
              cur_d   = nxt_auto[SW-1:0];
              chg_d   = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end
        end

        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase

      // Display outputs follow the state being entered.
      case (state_d)
        S_SHOW: begin
          data_d = src_arr[cur_d];
          en_d   = 1'b1;
        end
        S_GAP: begin
          en_d = 1'b0;
        end
        default: begin
          data_d = 8'd0;
          en_d   = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset overrides freeze.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
      nxt_q   <= '0;
      data_q  <= 8'd0;
      en_q    <= 1'b0;
      chg_q   <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      data_q  <= data_d;
      en_q    <= en_d;
      chg_q   <= chg_d;
      mode_q  <= mode_d;
    end
  end

  assign data_out = data_q;
  assign disp_en  = en_q;
  assign cur_src  = cur_q;
  assign changed  = chg_q;

endmodule

// File: tb/tb_display_scheduler.sv
module tb_display_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] src_data;
  logic [3:0]  src_valid;
  logic        mode;
  logic [1:0]  sel;
  logic        freeze;
  logic [7:0]  data_out;
  logic        disp_en;
  logic [1:0]  cur_src;
  logic        changed;

  display_scheduler #(.N_SRC(4), .DWELL(4), .GAP(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .src_data  (src_data),
    .src_valid (src_valid),
    .mode      (mode),
    .sel       (sel),
    .freeze    (freeze),
    .data_out  (data_out),
    .disp_en   (disp_en),
    .cur_src   (cur_src),
    .changed   (changed)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        rst;
    logic [31:0] d;
    logic [3:0]  v;
    logic        md;
    logic [1:0]  s;
    logic        frz;
    logic [7:0]  e_data;
    logic        e_en;
    logic [1:0]  e_cur;
    logic        e_chg;
  } vec_t;

  vec_t vq[$];
  vec_t cin;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   done  = 1'b0;

  localparam logic [31:0] D0 = {8'd44, 8'd33, 8'd22, 8'd11};
  localparam logic [31:0] D1 = {8'd44, 8'd33, 8'd77, 8'd11};

  task automatic e(input logic [7:0] ed, input logic en, input logic [1:0] c,
                   input logic ch, input int n = 1);
    vec_t t;
    t = cin;
    t.e_data = ed;
    t.e_en   = en;
    t.e_cur  = c;
    t.e_chg  = ch;
    for (int k = 0; k < n; k++) vq.push_back(t);
  endtask

  task automatic rst_row();
    cin.rst = 1'b1;
    e(8'd0, 1'b0, 2'd0, 1'b0);
    cin.rst = 1'b0;
  endtask

  initial begin
    #200000;
    if (!done) begin
      n_bad++;
      $display("FAIL timeout: stimulus did not complete, %0d vectors applied", n_vec);
      $display("== FAIL ==");
      $finish;
    end
  end

  initial begin
    logic [7:0] dv [4];
    dv[0] = 8'd11; dv[1] = 8'd22; dv[2] = 8'd33; dv[3] = 8'd44;

    cin.tag = "t1_rr"; cin.rst = 1'b0; cin.d = D0; cin.v = 4'b1111;
    cin.md = 1'b0; cin.s = 2'd0; cin.frz = 1'b0;

    rst_row();
    for (int k = 0; k < 4; k++) begin
      e(dv[k], 1'b1, 2'(k), 1'b1);
      e(dv[k], 1'b1, 2'(k), 1'b0, 3);
      e(dv[k], 1'b0, 2'(k), 1'b0, 2);
    end
    e(8'd11, 1'b1, 2'd0, 1'b1);

    cin.tag = "t2_sparse"; cin.v = 4'b1010;
    rst_row();
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        e(8'd22, 1'b1, 2'd1, 1'b1); e(8'd22, 1'b1, 2'd1, 1'b0, 3); e(8'd22, 1'b0, 2'd1, 1'b0, 2);
      end else begin
        e(8'd44, 1'b1, 2'd3, 1'b1); e(8'd44, 1'b1, 2'd3, 1'b0, 3); e(8'd44, 1'b0, 2'd3, 1'b0, 2);
      end
    end
    e(8'd22, 1'b1, 2'd1, 1'b1);

    cin.tag = "t3_single"; cin.v = 4'b0100;
    rst_row();
    e(8'd33, 1'b1, 2'd2, 1'b1);
    e(8'd33, 1'b1, 2'd2, 1'b0, 12);

    cin.tag = "t4_manual"; cin.v = 4'b1111; cin.md = 1'b1; cin.s = 2'd0;
    rst_row();
    e(8'd11, 1'b1, 2'd0, 1'b1);
    e(8'd11, 1'b1, 2'd0, 1'b0);
    cin.s = 2'd2;
    e(8'd11, 1'b0, 2'd0, 1'b0, 2);
    e(8'd33, 1'b1, 2'd2, 1'b1);
    cin.s = 2'd3; cin.v = 4'b0111;
    e(8'd33, 1'b1, 2'd2, 1'b0, 6);

    cin.tag = "t5_freeze"; cin.md = 1'b0; cin.s = 2'd0; cin.v = 4'b1111;
    rst_row();
    e(8'd11, 1'b1, 2'd0, 1'b1);
    e(8'd11, 1'b1, 2'd0, 1'b0, 3);
    e(8'd11, 1'b0, 2'd0, 1'b0, 2);
    e(8'd22, 1'b1, 2'd1, 1'b1);
    e(8'd22, 1'b1, 2'd1, 1'b0);
    cin.frz = 1'b1; cin.d = D1;
    e(8'd22, 1'b1, 2'd1, 1'b0, 3);
    cin.frz = 1'b0;
    e(8'd77, 1'b1, 2'd1, 1'b0, 2);
    e(8'd77, 1'b0, 2'd1, 1'b0, 2);
    e(8'd33, 1'b1, 2'd2, 1'b1);

    cin.tag = "t6_drop"; cin.v = 4'b1011;
    e(8'd33, 1'b0, 2'd2, 1'b0, 2);
    e(8'd44, 1'b1, 2'd3, 1'b1);
    cin.v = 4'b0000;
    e(8'd0, 1'b0, 2'd3, 1'b0);
    cin.v = 4'b1111;
    e(8'd11, 1'b1, 2'd0, 1'b1);
    e(8'd11, 1'b1, 2'd0, 1'b0, 3);
    e(8'd11, 1'b0, 2'd0, 1'b0);
    cin.tag = "t6_rst"; cin.frz = 1'b1;
    rst_row();
    cin.frz = 1'b0; cin.v = 4'b0000;
    e(8'd0, 1'b0, 2'd0, 1'b0, 2);

    reset = 1'b1; src_data = D0; src_valid = '0; mode = 1'b0; sel = '0; freeze = 1'b0;
    foreach (vq[i]) begin
      reset     = vq[i].rst;
      src_data  = vq[i].d;
      src_valid = vq[i].v;
      mode      = vq[i].md;
      sel       = vq[i].s;
      freeze    = vq[i].frz;
      @(posedge clk);
      #1;
      n_vec++;
      if (data_out !== vq[i].e_data) begin
        n_bad++;
        $display("FAIL %s vec %0d: data_out got %0d want %0d", vq[i].tag, i, data_out, vq[i].e_data);
      end
      if (disp_en !== vq[i].e_en) begin
        n_bad++;
        $display("FAIL %s vec %0d: disp_en got %0b want %0b", vq[i].tag, i, disp_en, vq[i].e_en);
      end
      if (cur_src !== vq[i].e_cur) begin
        n_bad++;
        $display("FAIL %s vec %0d: cur_src got %0d want %0d", vq[i].tag, i, cur_src, vq[i].e_cur);
      end
      if (changed !== vq[i].e_chg) begin
        n_bad++;
        $display("FAIL %s vec %0d: changed got %0b want %0b", vq[i].tag, i, changed, vq[i].e_chg);
      end
    end

    reset = 1'b1; src_valid = 4'b1111; mode = 1'b0; freeze = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if (data_out !== 8'd0 || disp_en !== 1'b0 || cur_src !== 2'd0 || changed !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: got data=%0d en=%0b cur=%0d chg=%0b",
               data_out, disp_en, cur_src, changed);
    end
    reset = 1'b0;

    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    if (n_bad == 0) $display("== PASS ==");
    else            $display("== FAIL ==");
    $finish;
  end

endmodule
